// File: rtl/scan_texture_loader.sv
// Scan-chain texture loader: synchronises phi1/phi2/sdi/latch, assembles frames, issues texel writes.
// Optional SCAN_TEXTURE_PARITY_EN appends an even-parity bit after the data field.
module scan_texture_loader #(
  parameter  int ADDR_W    = 11,
  parameter  int DATA_W    = 8,
  parameter  int BANK_W    = 1,
  localparam int NUM_BANKS = 2**BANK_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   phi1,
  input  logic                   phi2,
  input  logic                   sdi,
  input  logic                   latch,
  input  logic                   wr_ready,
  output logic                   wr_valid,
  output logic [NUM_BANKS-1:0]   wr_bank,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [ADDR_W+BANK_W:0] load_cnt,
  output logic                   frame_err,
  output logic                   overrun
);

`ifdef SCAN_TEXTURE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FLEN  = 1 + BANK_W + ADDR_W + DATA_W + PAR_W;
  localparam int SR_W  = FLEN - 1;
  localparam int CNT_W = $clog2(FLEN + 1);
  localparam int LC_W  = ADDR_W + BANK_W + 1;
  localparam logic [LC_W-1:0]      LC_MAX   = {1'b1, {(LC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FLEN);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_BANKS-1:0] BANK_ONE = NUM_BANKS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    WRITE
  } state_t;

  logic [1:0] r_p1_sy, r_p2_sy, r_lt_sy, r_sd_sy;
  logic       r_p1_d, r_p2_d, r_lt_d;
  logic       r_p1_e, r_p2_e, r_lt_e;

  // Pin -> 2 sync flops -> registered rise pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_sy <= '0;
      r_p2_sy <= '0;
      r_lt_sy <= '0;
      r_sd_sy <= '1;
      r_p1_d  <= 1'b0;
      r_p2_d  <= 1'b0;
      r_lt_d  <= 1'b0;
      r_p1_e  <= 1'b0;
      r_p2_e  <= 1'b0;
      r_lt_e  <= 1'b0;
    end else begin
      r_p1_sy <= {r_p1_sy[0], phi1};
      r_p2_sy <= {r_p2_sy[0], phi2};
      r_lt_sy <= {r_lt_sy[0], latch};
      r_sd_sy <= {r_sd_sy[0], sdi};
      r_p1_d  <= r_p1_sy[1];
      r_p2_d  <= r_p2_sy[1];
      r_lt_d  <= r_lt_sy[1];
      r_p1_e  <= r_p1_sy[1] & ~r_p1_d;
      r_p2_e  <= r_p2_sy[1] & ~r_p2_d;
      r_lt_e  <= r_lt_sy[1] & ~r_lt_d;
    end
  end

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [SR_W-1:0]     r_sr;
  logic                r_master;
  logic [NUM_BANKS-1:0] r_bank;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [LC_W-1:0]     r_lcnt;
  logic                r_ferr, r_ovr;

  logic                w_bit;
  logic                w_shift, w_load, w_err, w_ovr, w_xfer;
  logic [BANK_W-1:0]   w_f_bank;
  logic [ADDR_W-1:0]   w_f_addr;
  logic [DATA_W-1:0]   w_f_data;

  // Coincident phi1/phi2 rises: the freshly captured bit is the one shifted
  assign w_bit    = r_p1_e ? r_sd_sy[1] : r_master;
  assign w_f_data = r_sr[PAR_W +: DATA_W];
  assign w_f_addr = r_sr[PAR_W+DATA_W +: ADDR_W];
  assign w_f_bank = r_sr[PAR_W+DATA_W+ADDR_W +: BANK_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift   = 1'b0;
    w_load    = 1'b0;
    w_err     = 1'b0;
    w_ovr     = 1'b0;
    w_xfer    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_p2_e && !w_bit) begin
          w_state_n = SHIFT;
          w_cnt_n   = CNT_ONE;
        end
      end
      SHIFT: begin
        if (r_lt_e) begin
          w_err     = 1'b1;
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (r_p2_e) begin
          w_shift = 1'b1;
          w_cnt_n = r_cnt + CNT_ONE;
          if (w_cnt_n == CNT_FULL) w_state_n = FULL;
        end
      end
      FULL: begin
        if (r_p2_e) begin
          w_err     = 1'b1;
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (r_lt_e) begin
          w_cnt_n = '0;
`ifdef SCAN_TEXTURE_PARITY_EN
          if (^r_sr[DATA_W:0]) begin
            w_err     = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_load    = 1'b1;
            w_state_n = WRITE;
          end
`else
          w_load    = 1'b1;
          w_state_n = WRITE;
`endif
        end
      end
      WRITE: begin
        w_ovr = r_lt_e;
        // Bits arriving during a stalled write build the next frame
        if (r_p2_e) begin
          if (r_cnt == '0) begin
            if (!w_bit) w_cnt_n = CNT_ONE;
          end else if (r_cnt != CNT_FULL) begin
            w_shift = 1'b1;
            w_cnt_n = r_cnt + CNT_ONE;
          end
        end
        if (wr_ready) begin
          w_xfer = 1'b1;
          if (w_cnt_n == '0)           w_state_n = IDLE;
          else if (w_cnt_n == CNT_FULL) w_state_n = FULL;
          else                          w_state_n = SHIFT;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_sr     <= '0;
      r_master <= 1'b1;
      r_bank   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_lcnt   <= '0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_n;
      if (r_p1_e)  r_master <= r_sd_sy[1];
      if (w_shift) r_sr <= {r_sr[SR_W-2:0], w_bit};
      if (w_load) begin
        r_bank <= BANK_ONE << w_f_bank;
        r_addr <= w_f_addr;
        r_data <= w_f_data;
      end
      if (w_xfer && r_lcnt != LC_MAX) r_lcnt <= r_lcnt + LC_W'(1);
      if (w_err) r_ferr <= 1'b1;
      if (w_ovr) r_ovr  <= 1'b1;
    end
  end

  assign wr_valid  = (r_state == WRITE);
  assign wr_bank   = r_bank;
  assign wr_addr   = r_addr;
  assign wr_data   = r_data;
  assign load_cnt  = r_lcnt;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
